// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : skew_feeder
// Purpose  : Holds a DIM x DIM operand matrix and streams it into a systolic
//            array with the classic diagonal skew. At step t, lane k carries
//            buf[t-k][k] whenever that row index lies inside the matrix, so
//            lane k starts k cycles after lane 0.
// Ports    : clk      - single clock, rising edge
//            rst_n    - asynchronous active-low reset (also clears the buffer)
//            en       - stream advance enable (0 = stall, outputs held)
//            wr_en    - write one buffer row (accepted only when idle)
//            wr_row   - row index for the write
//            wr_data  - row data, lane k in [k*BITS +: BITS]
//            start    - begin streaming the buffered matrix
//            a_out    - skewed operands, lane k feeds array row k
//            a_valid  - per-lane valid for a_out
//            busy     - high while streaming (including stalls)
//            done     - one-cycle pulse when the stream finishes
// Revision : 1.0 - initial release
// ============================================================================
module skew_feeder #(
    parameter int DIM  = 8,
    parameter int BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [$clog2(DIM)-1:0]  wr_row,
    input  logic [DIM*BITS-1:0]     wr_data,
    input  logic                    start,
    output logic [DIM*BITS-1:0]     a_out,
    output logic [DIM-1:0]          a_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int c_RW = $clog2(DIM);
    localparam int c_TW = $clog2(2*DIM-1);
    localparam logic [c_TW-1:0] c_LAST = c_TW'(2*DIM-2);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_TW-1:0]        r_t;
    logic [c_TW-1:0]        w_t_nxt;
    // Step whose lane values get registered on this edge (only meaningful
    // when w_load is set).
    logic [c_TW-1:0]        w_step;
    logic                   w_load;
    logic                   w_clear;
    logic                   w_done_nxt;
    logic                   w_wr;

    logic signed [BITS-1:0] r_buf [DIM][DIM];

    logic [DIM*BITS-1:0]    r_a_out;
    logic [DIM-1:0]         r_a_valid;
    logic                   r_done;
    logic [DIM*BITS-1:0]    w_lane_a;
    logic [DIM-1:0]         w_lane_v;
    logic [DIM*BITS-1:0]    w_a_nxt;
    logic [DIM-1:0]         w_v_nxt;
    int                     w_diff;

    // Writes are only taken when idle; a simultaneous start wins so the
    // matrix being streamed is never modified.
    assign w_wr = (r_state == S_IDLE) && wr_en && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (w_wr) begin
            for (int c = 0; c < DIM; c++) begin
                r_buf[wr_row][c] <= wr_data[c*BITS +: BITS];
            end
        end
    end

    // Next-state / step control.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_step      = r_t;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_STREAM;
                    w_t_nxt     = '0;
                    w_step      = '0;
                    w_load      = 1'b1;
                end
            end
            S_STREAM: begin
                if (en) begin
                    if (r_t == c_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_t_nxt     = '0;
                        w_clear     = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_t_nxt = r_t + c_TW'(1);
                        w_step  = r_t + c_TW'(1);
                        w_load  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Diagonal gather: lane k shows row (step - k) of column k.
    always_comb begin
        w_lane_a = '0;
        w_lane_v = '0;
        w_diff   = 0;
        for (int k = 0; k < DIM; k++) begin
            w_diff = int'(w_step) - k;
            if ((w_diff >= 0) && (w_diff < DIM)) begin
                w_lane_v[k]               = 1'b1;
                w_lane_a[k*BITS +: BITS]  = r_buf[w_diff[c_RW-1:0]][k];
            end
        end
    end

    assign w_a_nxt = w_load ? w_lane_a : (w_clear ? '0 : r_a_out);
    assign w_v_nxt = w_load ? w_lane_v : (w_clear ? '0 : r_a_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_a_out   <= '0;
            r_a_valid <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_a_out   <= w_a_nxt;
            r_a_valid <= w_v_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign a_out   = r_a_out;
    assign a_valid = r_a_valid;
    assign done    = r_done;
    assign busy    = (r_state == S_STREAM);

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_feeder
// Purpose  : Scoreboard bench for skew_feeder (DIM=8, BITS=8). Stimulus
//            pushes the expected output word for every cycle in which the
//            design should present valid data or a done pulse; a monitor on
//            the falling edge pops and compares. Directed spot values are
//            also checked at known steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

    localparam int D    = 8;
    localparam int B    = 8;
    localparam int LAST = 2*D-2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           wr_en;
    logic [2:0]     wr_row;
    logic [D*B-1:0] wr_data;
    logic           start;
    logic [D*B-1:0] a_out;
    logic [D-1:0]   a_valid;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    skew_feeder #(.DIM(D), .BITS(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .start   (start),
        .a_out   (a_out),
        .a_valid (a_valid),
        .busy    (busy),
        .done    (done)
    );

    typedef struct packed {
        logic [D*B-1:0] a;
        logic [D-1:0]   v;
        logic           b;
        logic           d;
    } item_t;

    item_t      q[$];
    logic [B-1:0] mbuf [D][D];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic item_t mk(input int s);
        item_t it;
        it = '0;
        for (int k = 0; k < D; k++) begin
            if ((s - k >= 0) && (s - k < D)) begin
                it.a[k*B +: B] = mbuf[s-k][k];
                it.v[k]        = 1'b1;
            end
        end
        it.b = 1'b1;
        it.d = 1'b0;
        return it;
    endfunction

    function automatic item_t mk_done();
        item_t it;
        it   = '0;
        it.d = 1'b1;
        return it;
    endfunction

    function automatic logic [B-1:0] lane(input int k);
        return a_out[k*B +: B];
    endfunction

    // Monitor: whenever the design presents data or done, compare with the
    // oldest expectation.
    always @(negedge clk) begin
        item_t e;
        if (rst_n && ((a_valid != '0) || done)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=%h/%h/%b/%b required=none",
                         a_out, a_valid, busy, done);
            end else begin
                e = q.pop_front();
                chk("sb_aout",  a_out,   e.a);
                chk("sb_valid", a_valid, e.v);
                chk("sb_busy",  busy,    e.b);
                chk("sb_done",  done,    e.d);
            end
        end
    end

    task automatic wr_row_t(input int r, input logic [D*B-1:0] d);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    // Spot checks with hand-computed values for buf[r][c] = r*8+c+1.
    task automatic spot(input int tid, input int s);
        if (tid == 1 && s == 0) begin
            chk("s0_valid", a_valid, 64'h01);
            chk("s0_lane0", lane(0), 64'd1);
        end
        if (tid == 1 && s == 3) begin
            chk("s3_valid", a_valid, 64'h0F);
            chk("s3_lane0", lane(0), 64'd25);
            chk("s3_lane3", lane(3), 64'd4);
        end
        if (tid == 1 && s == 14) begin
            chk("s14_valid", a_valid, 64'h80);
            chk("s14_lane7", lane(7), 64'd64);
        end
        if (tid == 3 && s == 0) begin
            chk("rewr_lane0", lane(0), 64'd1);
        end
        if (tid == 4 && s == 0) begin
            chk("neg_lane0", lane(0), 64'h80);
            chk("neg_sign",  $signed(lane(0)) < 0, 64'd1);
        end
    endtask

    task automatic run_stream(input int stall_at, input int stall_len,
                              input bit wr_during, input int abort_at, input int tid);
        start = 1'b1;
        en    = 1'b1;
        q.push_back(mk(0));
        if (wr_during) begin
            wr_en   = 1'b1;
            wr_row  = 3'd0;
            wr_data = {D{8'h7F}};
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s <= LAST; s++) begin
            spot(tid, s);
            if (s == abort_at) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #1;
                chk("abort_aout",  a_out,   64'd0);
                chk("abort_valid", a_valid, 64'd0);
                chk("abort_busy",  busy,    64'd0);
                chk("abort_done",  done,    64'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_hold_done", done, 64'd0);
                end
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("abort_post_busy", busy, 64'd0);
                chk("abort_post_done", done, 64'd0);
                return;
            end
            if (s == stall_at) begin
                repeat (stall_len) begin
                    en = 1'b0;
                    q.push_back(mk(s));
                    @(posedge clk); #1;
                end
                en = 1'b1;
                if (tid == 2) begin
                    chk("stall_lane0", lane(0), 64'd41);
                    chk("stall_lane5", lane(5), 64'd6);
                    chk("stall_busy",  busy,    64'd1);
                end
            end
            if (s == LAST) begin
                wr_en = 1'b0;
                q.push_back(mk_done());
            end else begin
                q.push_back(mk(s + 1));
            end
            @(posedge clk); #1;
        end
        chk("end_done", done,  64'd1);
        chk("end_busy", busy,  64'd0);
        chk("end_aout", a_out, 64'd0);
        @(posedge clk); #1;
        chk("post_done_low", done, 64'd0);
    endtask

    initial begin
        logic [D*B-1:0] row;
        rst_n   = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        start   = 1'b0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                mbuf[r][c] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_aout",  a_out,   64'd0);
        chk("rst_valid", a_valid, 64'd0);
        chk("rst_busy",  busy,    64'd0);
        chk("rst_done",  done,    64'd0);

        // Load buf[r][c] = r*8 + c + 1.
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < D; c++) begin
                mbuf[r][c]   = 8'(r*8 + c + 1);
                row[c*B +: B] = 8'(r*8 + c + 1);
            end
            wr_row_t(r, row);
        end

        run_stream(-1, 0, 1'b0, -1, 1);   // plain stream
        run_stream( 5, 3, 1'b0, -1, 2);   // 3-cycle stall at step 5
        run_stream(-1, 0, 1'b1, -1, 0);   // writes during busy / start edge
        run_stream(-1, 0, 1'b0, -1, 3);   // data must be unchanged
        run_stream(-1, 0, 1'b0,  7, 0);   // reset at step 7
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++)
                mbuf[r][c] = '0;
        run_stream(-1, 0, 1'b0, -1, 0);   // all-zero data, same valid skew

        row = '0;
        row[7:0] = 8'h80;
        mbuf[0][0] = 8'h80;
        wr_row_t(0, row);
        run_stream(-1, 0, 1'b0, -1, 4);   // negative operand

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
